// File: rtl/ob_client.sv
// ob_client: initiator front end for the order-book command/response interface.
// Issues commands to ob, tracks live uids in a small table, matches responses, flags misses/timeouts.
package ob_pkg;
  typedef struct packed {
    logic [7:0]  uid;
    logic [1:0]  op;
    logic [15:0] data;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  uid;
    logic [1:0]  status;
    logic [15:0] data;
  } rsp_t;
endpackage

// state | meaning
// RUN   | normal operation, commands accepted and issued
// DRAIN | issue blocked, waiting for the table to empty
// DONE  | table empty, drain_done asserted for this cycle
module ob_client #(
  parameter int MAX_OUT    = 4,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  ob_pkg::cmd_t                 in_cmd,
  output logic                         in_rdy,
  output logic                         cmd_vld_r,
  output ob_pkg::cmd_t                 cmd_r,
  input  logic                         cmd_full_r,
  input  logic                         rsp_vld,
  input  ob_pkg::rsp_t                 rsp,
  output logic                         rsp_accept,
  output logic                         out_vld,
  output ob_pkg::rsp_t                 out_rsp,
  input  logic                         out_rdy,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic                         err_unexp,
  output logic                         err_tmo,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);
  import ob_pkg::*;

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int AW = $clog2(TMO_CYCLES);
  localparam logic [AW-1:0] AGE_MAX = AW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [MAX_OUT-1:0]   vld_q;
  logic [7:0]           uid_q [MAX_OUT];
  logic [AW-1:0]        age_q [MAX_OUT];
  logic                 cmd_vld_q;
  cmd_t                 cmd_q;
  logic                 out_vld_q;
  rsp_t                 out_rsp_q;
  logic                 err_unexp_q;
  logic                 err_tmo_q;

  logic [OW-1:0]        live_cnt;
  logic                 dup;
  logic                 free_found;
  logic [IW-1:0]        alloc_idx;
  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 alloc;
  logic                 rsp_hit;
  logic                 rsp_miss;
  logic [MAX_OUT-1:0]   tmo_vec;

  always_comb begin
    live_cnt   = '0;
    dup        = 1'b0;
    free_found = 1'b0;
    alloc_idx  = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (vld_q[i]) live_cnt = live_cnt + OW'(1);
      if (vld_q[i] && (uid_q[i] == in_cmd.uid)) dup = 1'b1;
      if (!vld_q[i] && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
      if (vld_q[i] && (uid_q[i] == rsp.uid) && !hit) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign in_rdy     = (state_q == S_RUN) && !cmd_full_r && (live_cnt < OW'(MAX_OUT))
                      && free_found && !dup;
  assign alloc      = in_vld && in_rdy;
  assign rsp_accept = rsp_vld && (!out_vld_q || out_rdy);
  assign rsp_hit    = rsp_accept && hit;
  assign rsp_miss   = rsp_accept && !hit;

  // A response arriving on the entry's last cycle wins over the timeout.
  always_comb begin
    tmo_vec = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      tmo_vec[i] = vld_q[i] && (age_q[i] == AGE_MAX) && !(rsp_hit && (hit_idx == IW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        uid_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (alloc && (alloc_idx == IW'(i))) begin
          vld_q[i] <= 1'b1;
          uid_q[i] <= in_cmd.uid;
          age_q[i] <= '0;
        end else if ((rsp_hit && (hit_idx == IW'(i))) || tmo_vec[i]) begin
          vld_q[i] <= 1'b0;
          age_q[i] <= '0;
        end else if (vld_q[i]) begin
          age_q[i] <= age_q[i] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      out_vld_q   <= 1'b0;
      out_rsp_q   <= '0;
      err_unexp_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      cmd_vld_q   <= alloc;
      if (alloc) cmd_q <= in_cmd;
      if (rsp_hit) begin
        out_vld_q <= 1'b1;
        out_rsp_q <= rsp;
      end else if (out_rdy) begin
        out_vld_q <= 1'b0;
      end
      err_unexp_q <= rsp_miss;
      err_tmo_q   <= |tmo_vec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (drain_req) state_d = S_DRAIN;
      S_DRAIN: if (live_cnt == '0) state_d = S_DONE;
      S_DONE:  state_d = drain_req ? S_DRAIN : S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign drain_done  = (state_q == S_DONE);
  assign cmd_vld_r   = cmd_vld_q;
  assign cmd_r       = cmd_q;
  assign out_vld     = out_vld_q;
  assign out_rsp     = out_rsp_q;
  assign err_unexp   = err_unexp_q;
  assign err_tmo     = err_tmo_q;
  assign outstanding = live_cnt;
endmodule
